// File: rtl/commit_reorder_queue.sv
// commit_reorder_queue: in-order retirement buffer sitting in front of the
// commit stage. Entries are allocated at the tail on issue, filled out of
// order by writebacks addressed by transaction ID, and retired from the head
// in order through up to NR_COMMIT_PORTS commit ports.
module commit_reorder_queue #(
  parameter int unsigned NR_ENTRIES      = 8,
  parameter int unsigned TRANS_ID_BITS   = 3,
  parameter int unsigned XLEN            = 32,
  parameter int unsigned NR_WB_PORTS     = 4,
  parameter int unsigned NR_COMMIT_PORTS = 2
) (
  input  logic                                   clk_i,
  input  logic                                   rst_ni,
  input  logic                                   flush_i,
  input  logic                                   issue_valid_i,
  input  logic [XLEN-1:0]                        issue_pc_i,
  input  logic [4:0]                             issue_rd_i,
  output logic                                   issue_ready_o,
  output logic [TRANS_ID_BITS-1:0]               issue_trans_id_o,
  input  logic [NR_WB_PORTS-1:0]                 wb_valid_i,
  input  logic [NR_WB_PORTS*TRANS_ID_BITS-1:0]   wb_trans_id_i,
  input  logic [NR_WB_PORTS*XLEN-1:0]            wb_data_i,
  input  logic [NR_WB_PORTS-1:0]                 wb_ex_i,
  output logic [NR_COMMIT_PORTS-1:0]             commit_valid_o,
  output logic [NR_COMMIT_PORTS*TRANS_ID_BITS-1:0] commit_trans_id_o,
  output logic [NR_COMMIT_PORTS*XLEN-1:0]        commit_pc_o,
  output logic [NR_COMMIT_PORTS*5-1:0]           commit_rd_o,
  output logic [NR_COMMIT_PORTS*XLEN-1:0]        commit_result_o,
  output logic [NR_COMMIT_PORTS-1:0]             commit_ex_o,
  input  logic [NR_COMMIT_PORTS-1:0]             commit_ack_i
);

  localparam int unsigned CNT_W = TRANS_ID_BITS + 1;

  // Per-entry state
  logic [NR_ENTRIES-1:0] busy_q;
  logic [NR_ENTRIES-1:0] done_q;
  logic [NR_ENTRIES-1:0] ex_q;
  logic [XLEN-1:0]       pc_q     [NR_ENTRIES];
  logic [4:0]            rd_q     [NR_ENTRIES];
  logic [XLEN-1:0]       result_q [NR_ENTRIES];

  // Queue pointers; full/empty are decided by count, never by the pointers
  logic [TRANS_ID_BITS-1:0] head_q;
  logic [TRANS_ID_BITS-1:0] tail_q;
  logic [CNT_W-1:0]         count_q;

  logic                     issue_fire;
  logic [TRANS_ID_BITS-1:0] commit_idx [NR_COMMIT_PORTS];
  logic [NR_COMMIT_PORTS-1:0] ack_accept;
  logic [CNT_W-1:0]         ack_count;
  logic                     present_chain;
  logic                     ack_chain;
  logic [TRANS_ID_BITS-1:0] wb_id   [NR_WB_PORTS];
  logic [XLEN-1:0]          wb_data [NR_WB_PORTS];

  // Readiness looks only at registered occupancy, so a same-cycle ack never frees a slot
  assign issue_ready_o    = (count_q != CNT_W'(NR_ENTRIES));
  assign issue_trans_id_o = tail_q;
  assign issue_fire       = issue_valid_i && issue_ready_o;

  // Split the flat writeback buses into per-port ID and data
  always_comb begin
    for (int p = 0; p < NR_WB_PORTS; p++) begin
      wb_id[p]   = wb_trans_id_i[p*TRANS_ID_BITS +: TRANS_ID_BITS];
      wb_data[p] = wb_data_i[p*XLEN +: XLEN];
    end
  end

  // Present consecutive head entries; an exception entry stops the chain behind it
  always_comb begin
    commit_valid_o    = '0;
    commit_trans_id_o = '0;
    commit_pc_o       = '0;
    commit_rd_o       = '0;
    commit_result_o   = '0;
    commit_ex_o       = '0;
    present_chain     = 1'b1;
    for (int k = 0; k < NR_COMMIT_PORTS; k++) begin
      commit_idx[k] = head_q + TRANS_ID_BITS'(k);
      commit_valid_o[k] = present_chain && busy_q[commit_idx[k]] && done_q[commit_idx[k]];
      commit_ex_o[k]    = ex_q[commit_idx[k]];
      commit_trans_id_o[k*TRANS_ID_BITS +: TRANS_ID_BITS] = commit_idx[k];
      commit_pc_o[k*XLEN +: XLEN]     = pc_q[commit_idx[k]];
      commit_rd_o[k*5 +: 5]           = rd_q[commit_idx[k]];
      commit_result_o[k*XLEN +: XLEN] = result_q[commit_idx[k]];
      present_chain = commit_valid_o[k] && !ex_q[commit_idx[k]];
    end
  end

  // Accept acks only as an unbroken prefix of valid ports and count them
  always_comb begin
    ack_accept = '0;
    ack_count  = '0;
    ack_chain  = 1'b1;
    for (int k = 0; k < NR_COMMIT_PORTS; k++) begin
      ack_chain     = ack_chain && commit_ack_i[k] && commit_valid_o[k];
      ack_accept[k] = ack_chain;
      ack_count     = ack_count + CNT_W'(ack_chain);
    end
  end

  // Entry and pointer update; reset and flush discard everything, flush beats all other inputs
  always_ff @(posedge clk_i) begin
    if (!rst_ni || flush_i) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      busy_q  <= '0;
      done_q  <= '0;
      ex_q    <= '0;
      for (int e = 0; e < NR_ENTRIES; e++) begin
        pc_q[e]     <= '0;
        rd_q[e]     <= '0;
        result_q[e] <= '0;
      end
    end else begin
      // Walk ports from highest to lowest so the lowest index has the final say
      for (int p = NR_WB_PORTS - 1; p >= 0; p--) begin
        if (wb_valid_i[p] && busy_q[wb_id[p]] && !done_q[wb_id[p]]) begin
          done_q[wb_id[p]]   <= 1'b1;
          ex_q[wb_id[p]]     <= wb_ex_i[p];
          result_q[wb_id[p]] <= wb_data[p];
        end
      end
      for (int k = 0; k < NR_COMMIT_PORTS; k++) begin
        if (ack_accept[k]) begin
          busy_q[commit_idx[k]] <= 1'b0;
          done_q[commit_idx[k]] <= 1'b0;
        end
      end
      if (issue_fire) begin
        busy_q[tail_q] <= 1'b1;
        done_q[tail_q] <= 1'b0;
        ex_q[tail_q]   <= 1'b0;
        pc_q[tail_q]   <= issue_pc_i;
        rd_q[tail_q]   <= issue_rd_i;
      end
      head_q  <= head_q + ack_count[TRANS_ID_BITS-1:0];
      tail_q  <= tail_q + TRANS_ID_BITS'(issue_fire);
      count_q <= count_q + CNT_W'(issue_fire) - ack_count;
    end
  end

endmodule

// File: doc/commit_reorder_queue.md
Name: commit_reorder_queue

Overview:
- In-order retirement buffer directly upstream of the commit stage.
- Allocates an entry per issued instruction and collects out-of-order writebacks from the functional units by transaction ID.
- Presents up to NR_COMMIT_PORTS completed head entries per cycle to the commit stage, which acknowledges them in order.
- Lightweight replacement for the scoreboard's commit-side view in our softcore timing experiments.

Parameters:
NR_ENTRIES, 8, queue depth; power of two, at least 4
TRANS_ID_BITS, 3, log2(NR_ENTRIES); width of transaction IDs
XLEN, 32, result width
NR_WB_PORTS, 4, number of writeback ports
NR_COMMIT_PORTS, 2, number of commit ports

Ports:
clk_i  in  1  clock, rising edge
rst_ni  in  1  synchronous active-low reset
flush_i  in  1  discard all entries
issue_valid_i  in  1  allocate request
issue_pc_i  in  XLEN  PC of the allocated instruction
issue_rd_i  in  5  destination register
issue_ready_o  out  1  an entry is free
issue_trans_id_o  out  TRANS_ID_BITS  ID of the entry to allocate (equals tail pointer)
wb_valid_i  in  NR_WB_PORTS  writeback strobes
wb_trans_id_i  in  NR_WB_PORTS*TRANS_ID_BITS  writeback target IDs
wb_data_i  in  NR_WB_PORTS*XLEN  results
wb_ex_i  in  NR_WB_PORTS  result carries an exception
commit_valid_o  out  NR_COMMIT_PORTS  head entries are ready to retire
commit_trans_id_o  out  NR_COMMIT_PORTS*TRANS_ID_BITS  IDs of the presented entries
commit_pc_o  out  NR_COMMIT_PORTS*XLEN  PCs of the presented entries
commit_rd_o  out  NR_COMMIT_PORTS*5  destination registers
commit_result_o  out  NR_COMMIT_PORTS*XLEN  results
commit_ex_o  out  NR_COMMIT_PORTS  exception flags
commit_ack_i  in  NR_COMMIT_PORTS  retire acknowledges from the commit stage

Behaviour:
- State per entry: busy, done, ex, pc, rd, result. Pointers head, tail (TRANS_ID_BITS) and count (TRANS_ID_BITS+1) are registers.
- Reset (rst_ni=0 at clk edge):
  - head=tail=count=0; all busy/done/ex=0.
  - Outputs: issue_ready_o=1, issue_trans_id_o=0, commit_valid_o=0; other outputs are don't-care but driven from cleared registers (0).
  - Reset mid-operation discards everything, identical to flush.
- Issue:
  - issue_ready_o = (count != NR_ENTRIES). It depends only on registered state, with no combinational path from commit_ack_i. When full, an issue is refused even if an ack arrives in the same cycle.
  - issue_valid_i && issue_ready_o: entry[tail] gets busy=1, done=0, ex=0, pc, rd. tail increments, wrapping modulo NR_ENTRIES.
- Writeback:
  - For each port p with wb_valid_i[p], if entry[id] is busy and not done: done=1, result=data, ex=wb_ex_i[p].
  - Writeback to a non-busy or already-done entry is ignored.
  - Several ports targeting the same ID in one cycle: the lowest port index wins.
  - Effect is visible on the commit outputs the next cycle.
- Commit presentation (combinational from registers):
  - Port k presents entry head+k (mod NR_ENTRIES).
  - commit_valid_o[0] = busy && done of head.
  - commit_valid_o[k] = commit_valid_o[k-1] && !commit_ex_o[k-1] && busy && done of head+k. An exception entry is therefore only ever presented alone at the lowest valid port.
- Commit ack:
  - Acks are honoured as a prefix: ack[k] counts only if ack[0..k] are all 1 and commit_valid_o[k]=1. Ack on an invalid port, or a non-prefix ack, is ignored.
  - Acked entries are cleared (busy=0, done=0). head advances by the number of accepted acks.
- count_next = count + issue_accepted - acks_accepted. Simultaneous issue and commit in one cycle is legal.
- Latency: issue in cycle N, writeback in cycle N+1, commit_valid_o high in cycle N+2 at the earliest.
- Flush:
  - flush_i=1 clears everything exactly like reset on the next edge.
  - Issue, writeback and ack in the same cycle are ignored.
  - Flush has priority over all other inputs. rst_ni has priority over flush_i.
- Wrap-around:
  - Pointers wrap naturally.
  - Full is count==NR_ENTRIES with head==tail; empty is count==0 with head==tail. Full and empty are never inferred from the pointers alone.

Test Plan:
- Reset then idle -> issue_ready_o=1, issue_trans_id_o=0, commit_valid_o=2'b00.
- Issue PCs 0x100, 0x104, 0x108 (IDs 0,1,2); writeback ID2=0xC then ID0=0xA then ID1=0xB -> no commit until ID0 done. Then port0 presents ID0 result 0xA; after ID1 done both ports present ID0/ID1. Ack 2'b11 -> head=2, and ID2 is presented next cycle.
- Fill 8 entries -> issue_ready_o=0. Assert issue_valid_i together with ack[0] while full -> issue refused, count=7 next cycle, issue_ready_o=1.
- ID0 done with wb_ex_i=1 and ID1 done -> commit_valid_o=2'b01, commit_ex_o[0]=1. ack=2'b11 -> only one entry retires.
- Two ports writeback ID3 in the same cycle with data 0x11 (port1) and 0x22 (port3) -> result 0x11. A later writeback to ID3 is ignored.
- Run 20 issue/commit cycles so pointers wrap past 7, then flush_i with issue_valid_i=1 -> next cycle count=0, head=tail=0, commit_valid_o=0, no entry allocated.
